dual_pipe_drain_ctrl: RTL and testbench

Controller between the two parallel pipelines and a single downstream consumer. It buffers each pipeline's output in a small skid FIFO and generates the per-pipeline stall_1/stall_2 that the producer FSM consumes. It round-robin arbitrates both FIFOs onto one valid/ready output port and schedules periodic alternating flush_1/flush_2 pulses.

---
 rtl/dpdc_pkg.sv | 21 ++
 rtl/skid_fifo.sv | 64 ++++++
 rtl/dual_pipe_drain_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dual_pipe_drain_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpdc_pkg.sv
// Shared constants and types for the dual-pipeline drain controller.
package dpdc_pkg;

  localparam int unsigned DEFAULT_DATA_W       = 32;
  localparam int unsigned DEFAULT_FIFO_DEPTH   = 4;
  localparam int unsigned DEFAULT_STALL_THRESH = 2;
  localparam int unsigned DEFAULT_FLUSH_PERIOD = 64;

  localparam logic SRC_PIPE1 = 1'b0;
  localparam logic SRC_PIPE2 = 1'b1;

  typedef enum logic {
    FlushPipe1 = 1'b0,
    FlushPipe2 = 1'b1
  } flush_sel_e;

  function automatic flush_sel_e next_flush_sel(flush_sel_e cur);
    return (cur == FlushPipe1) ? FlushPipe2 : FlushPipe1;
  endfunction

endpackage

// File: rtl/skid_fifo.sv
// Small synchronous FIFO buffering one pipeline's results; clear empties it at end of cycle.
module skid_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CntW-1:0]   count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              wr_ok, rd_ok;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A write while full is dropped even if a read frees a slot this cycle.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CntW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/dual_pipe_drain_ctrl.sv
// Buffers two pipelines in skid FIFOs, round-robins them onto one valid/ready port,
// and issues periodic alternating flush pulses.
module dual_pipe_drain_ctrl
  import dpdc_pkg::*;
#(
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int unsigned STALL_THRESH = DEFAULT_STALL_THRESH,
  parameter int unsigned FLUSH_PERIOD = DEFAULT_FLUSH_PERIOD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p1_valid,
  input  logic [DATA_W-1:0] p1_data,
  input  logic              p2_valid,
  input  logic [DATA_W-1:0] p2_data,
  output logic              stall_1,
  output logic              stall_2,
  output logic              flush_1,
  output logic              flush_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic [1:0]        overflow
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FcW  = (FLUSH_PERIOD > 1) ? $clog2(FLUSH_PERIOD) : 1;

  logic [DATA_W-1:0] rd_data_1, rd_data_2;
  logic [CntW-1:0]   count_1, count_2;
  logic              full_1, full_2, empty_1, empty_2;
  logic              wr_en_1, wr_en_2;
  logic              grant_1, grant_2;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_src_q, out_src_d;
  logic              prio_q, prio_d;
  logic [1:0]        overflow_q, overflow_d;

  logic [FcW-1:0]    flush_cnt_q, flush_cnt_d;
  flush_sel_e        flush_sel_q, flush_sel_d;
  logic              flush_1_q, flush_1_d;
  logic              flush_2_q, flush_2_d;
  logic              flush_fire;

  // A lane being flushed neither accepts nor supplies words this cycle.
  assign wr_en_1 = p1_valid & ~flush_1_q;
  assign wr_en_2 = p2_valid & ~flush_2_q;

  skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo_1 (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush_1_q),
    .wr_en   (wr_en_1),
    .wr_data (p1_data),
    .rd_en   (grant_1),
    .rd_data (rd_data_1),
    .count   (count_1),
    .full    (full_1),
    .empty   (empty_1)
  );

  skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo_2 (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush_2_q),
    .wr_en   (wr_en_2),
    .wr_data (p2_data),
    .rd_en   (grant_2),
    .rd_data (rd_data_2),
    .count   (count_2),
    .full    (full_2),
    .empty   (empty_2)
  );

  assign stall_1 = (count_1 >= CntW'(STALL_THRESH));
  assign stall_2 = (count_2 >= CntW'(STALL_THRESH));

  // Arbitration and output register.
  always_comb begin
    logic load;
    logic avail_1, avail_2;

    grant_1     = 1'b0;
    grant_2     = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    prio_d      = prio_q;

    load    = ~out_valid_q | out_ready;
    avail_1 = ~empty_1 & ~flush_1_q;
    avail_2 = ~empty_2 & ~flush_2_q;

    if (load) begin
      if (avail_1 && avail_2) begin
        grant_1 = (prio_q == SRC_PIPE1);
        grant_2 = (prio_q == SRC_PIPE2);
      end else begin
        grant_1 = avail_1;
        grant_2 = avail_2;
      end

      out_valid_d = grant_1 | grant_2;
      if (grant_1) begin
        out_data_d = rd_data_1;
        out_src_d  = SRC_PIPE1;
        prio_d     = SRC_PIPE2;
      end else if (grant_2) begin
        out_data_d = rd_data_2;
        out_src_d  = SRC_PIPE2;
        prio_d     = SRC_PIPE1;
      end
    end
  end

  // Overflow only counts words lost to a full FIFO, not words dropped by a flush.
  always_comb begin
    overflow_d    = overflow_q;
    overflow_d[0] = overflow_q[0] | (wr_en_1 & full_1);
    overflow_d[1] = overflow_q[1] | (wr_en_2 & full_2);
  end

  // Flush scheduler.
  always_comb begin
    flush_fire  = (flush_cnt_q == FcW'(FLUSH_PERIOD - 1));
    flush_cnt_d = flush_fire ? '0 : flush_cnt_q + FcW'(1);
    flush_1_d   = flush_fire & (flush_sel_q == FlushPipe1);
    flush_2_d   = flush_fire & (flush_sel_q == FlushPipe2);
    flush_sel_d = flush_fire ? next_flush_sel(flush_sel_q) : flush_sel_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= SRC_PIPE1;
      prio_q      <= SRC_PIPE1;
      overflow_q  <= '0;
      flush_cnt_q <= '0;
      flush_sel_q <= FlushPipe1;
      flush_1_q   <= 1'b0;
      flush_2_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      prio_q      <= prio_d;
      overflow_q  <= overflow_d;
      flush_cnt_q <= flush_cnt_d;
      flush_sel_q <= flush_sel_d;
      flush_1_q   <= flush_1_d;
      flush_2_q   <= flush_2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign overflow  = overflow_q;
  assign flush_1   = flush_1_q;
  assign flush_2   = flush_2_q;

endmodule

// File: tb/tb_dual_pipe_drain_ctrl.sv
// Self-checking bench: directed scenarios plus a random run against a queue-based model.
module tb_dual_pipe_drain_ctrl;

  localparam int unsigned DW     = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned THRESH = 2;
  localparam int unsigned PERIOD = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          p1_valid, p2_valid;
  logic [DW-1:0] p1_data, p2_data;
  logic          out_ready;
  logic          stall_1, stall_2, flush_1, flush_2;
  logic          out_valid, out_src;
  logic [DW-1:0] out_data;
  logic [1:0]    overflow;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  dual_pipe_drain_ctrl #(
    .DATA_W       (DW),
    .FIFO_DEPTH   (DEPTH),
    .STALL_THRESH (THRESH),
    .FLUSH_PERIOD (PERIOD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .p1_valid  (p1_valid),
    .p1_data   (p1_data),
    .p2_valid  (p2_valid),
    .p2_data   (p2_data),
    .stall_1   (stall_1),
    .stall_2   (stall_2),
    .flush_1   (flush_1),
    .flush_2   (flush_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .overflow  (overflow)
  );

  // Reference model: two word queues, one output slot, a preference bit and a cycle index.
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  bit            m_valid;
  logic [DW-1:0] m_data;
  bit            m_src;
  bit            m_prio;
  bit [1:0]      m_ovf;
  int            m_k;
  bit            mf1, mf2, mload, ma1, ma2, mfull1, mfull2;
  int            mg;

  // Flush n (n = 1, 2, ...) happens at cycle n*PERIOD after reset: odd n -> lane 1, even -> lane 2.
  function automatic bit m_flush(int k, int lane);
    if (k == 0 || (k % PERIOD) != 0) return 1'b0;
    return ((k / PERIOD) % 2) == ((lane == 0) ? 1 : 0);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        q1.delete();
        q2.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 1'b0;
        m_prio  = 1'b0;
        m_ovf   = 2'b00;
        m_k     = 0;
      end else begin
        mf1    = m_flush(m_k, 0);
        mf2    = m_flush(m_k, 1);
        mfull1 = (q1.size() == DEPTH);
        mfull2 = (q2.size() == DEPTH);
        mload  = !m_valid || out_ready;
        ma1    = (q1.size() > 0) && !mf1;
        ma2    = (q2.size() > 0) && !mf2;
        mg     = -1;
        if (ma1 && ma2) mg = m_prio ? 1 : 0;
        else if (ma1)   mg = 0;
        else if (ma2)   mg = 1;
        if (mload) begin
          if (mg == 0) begin
            m_data = q1.pop_front(); m_src = 1'b0; m_prio = 1'b1; m_valid = 1'b1;
          end else if (mg == 1) begin
            m_data = q2.pop_front(); m_src = 1'b1; m_prio = 1'b0; m_valid = 1'b1;
          end else begin
            m_valid = 1'b0;
          end
        end
        if (p1_valid && !mf1) begin
          if (mfull1) m_ovf[0] = 1'b1;
          else        q1.push_back(p1_data);
        end
        if (p2_valid && !mf2) begin
          if (mfull2) m_ovf[1] = 1'b1;
          else        q2.push_back(p2_data);
        end
        if (mf1) q1.delete();
        if (mf2) q2.delete();
        m_k++;
      end
    end
  end

  logic [39:0] got_vec, exp_vec;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        got_vec = {out_valid, out_src, out_data, stall_1, stall_2, flush_1, flush_2, overflow};
        exp_vec = {m_valid, m_src, m_data, (q1.size() >= THRESH), (q2.size() >= THRESH),
                   m_flush(m_k, 0), m_flush(m_k, 1), m_ovf};
        n_checks++;
        if (got_vec !== exp_vec) begin
          n_errors++;
          $display("FAIL scoreboard t=%0t {vld,src,data,st1,st2,fl1,fl2,ovf} got=%h exp=%h",
                   $time, got_vec, exp_vec);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    p1_valid  = 1'b0;
    p2_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      p1_valid = 1'b1;
      p1_data  = $urandom;
      step();
    end
    p1_valid = 1'b0;
    n_checks++;
    if (overflow !== 2'b01) begin
      n_errors++; $display("FAIL reset_pre_ovf got=%b exp=01", overflow);
    end
    do_reset();
    n_checks++;
    if ({out_valid, out_src, out_data, stall_1, stall_2, flush_1, flush_2, overflow} !== 40'h0) begin
      n_errors++;
      $display("FAIL reset_state got=%h exp=0",
               {out_valid, out_src, out_data, stall_1, stall_2, flush_1, flush_2, overflow});
    end
  endtask

  task automatic test_single_lane();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      p1_valid = (c < 3);
      p1_data  = 32'(2 * c);
      n_checks++;
      if (out_valid !== (c >= 2 && c <= 4)) begin
        n_errors++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 2 && c <= 4));
      end
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (out_data !== 32'(2 * (c - 2)) || out_src !== 1'b0) begin
          n_errors++;
          $display("FAIL single_data c=%0d got=%h/%b exp=%h/0", c, out_data, out_src, 2 * (c - 2));
        end
      end
      step();
    end
    p1_valid = 1'b0;
  endtask

  task automatic test_both_lanes();
    int idx1 = 0, idx2 = 0, exp_w = 0;
    bit d1, d2, s1_hi = 0, s1_lo = 0, s2_hi = 0, s2_lo = 0;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      p1_valid = !stall_1;
      p2_valid = !stall_2;
      p1_data  = 32'(2 * idx1);
      p2_data  = 32'(2 * idx2 + 1);
      if (c > 2) begin
        s1_hi |= stall_1; s1_lo |= !stall_1;
        s2_hi |= stall_2; s2_lo |= !stall_2;
      end
      if (out_valid) begin
        n_checks++;
        if (out_data !== 32'(exp_w) || out_src !== exp_w[0]) begin
          n_errors++;
          $display("FAIL both_seq got=%h/%b exp=%h/%b", out_data, out_src, exp_w, exp_w[0]);
        end
        exp_w++;
      end
      d1 = p1_valid;
      d2 = p2_valid;
      step();
      if (d1) idx1++;
      if (d2) idx2++;
    end
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    n_checks++;
    if (exp_w < 35 || overflow !== 2'b00) begin
      n_errors++; $display("FAIL both_rate words=%0d ovf=%b exp>=35/00", exp_w, overflow);
    end
    n_checks++;
    if ({s1_hi, s1_lo, s2_hi, s2_lo} !== 4'b1111) begin
      n_errors++; $display("FAIL both_stall_toggle got=%b exp=1111", {s1_hi, s1_lo, s2_hi, s2_lo});
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      p1_valid = !stall_1;
      p1_data  = 32'hA000 + 32'(n);
      if (p1_valid) n++;
      step();
    end
    n_checks++;
    if ({stall_1, overflow, out_valid, out_data} !== {1'b1, 2'b00, 1'b1, 32'hA000}) begin
      n_errors++;
      $display("FAIL bp_hold got st=%b ovf=%b v=%b d=%h exp 1/00/1/a000",
               stall_1, overflow, out_valid, out_data);
    end
    for (int j = 0; j < 2; j++) begin
      p1_valid = 1'b1;
      p1_data  = 32'hB000 + 32'(j);
      step();
    end
    n_checks++;
    if (overflow !== 2'b00) begin
      n_errors++; $display("FAIL bp_full_no_ovf got=%b exp=00", overflow);
    end
    p1_data = 32'hBEEF;
    step();
    p1_valid = 1'b0;
    n_checks++;
    if (overflow !== 2'b01 || out_data !== 32'hA000) begin
      n_errors++; $display("FAIL bp_overflow got=%b/%h exp=01/a000", overflow, out_data);
    end
  endtask

  task automatic test_flush_schedule();
    do_reset();
    for (int c = 0; c < 200; c++) begin
      n_checks++;
      if ({flush_1, flush_2} !== {(c == 64 || c == 192), (c == 128)}) begin
        n_errors++;
        $display("FAIL flush_sched c=%0d got=%b%b exp=%b%b", c, flush_1, flush_2,
                 (c == 64 || c == 192), (c == 128));
      end
      step();
    end
  endtask

  task automatic test_flush_drain();
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      p1_valid = 1'b1;
      p1_data  = 32'hC000 + 32'(c);
      step();
    end
    p1_valid = 1'b0;
    for (int c = 4; c < 63; c++) step();
    n_checks++;
    if ({stall_1, flush_1} !== 2'b10) begin
      n_errors++; $display("FAIL drain_pre got st=%b fl=%b exp=1/0", stall_1, flush_1);
    end
    step();
    p1_valid = 1'b1;
    p1_data  = 32'hDEAD;
    n_checks++;
    if (flush_1 !== 1'b1) begin
      n_errors++; $display("FAIL drain_pulse got=%b exp=1", flush_1);
    end
    step();
    p1_valid = 1'b0;
    n_checks++;
    if ({stall_1, flush_1, overflow, out_valid, out_data} !== {1'b0, 1'b0, 2'b00, 1'b1, 32'hC000}) begin
      n_errors++;
      $display("FAIL drain_post got st=%b fl=%b ovf=%b v=%b d=%h exp 0/0/00/1/c000",
               stall_1, flush_1, overflow, out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++; $display("FAIL drain_empty c=%0d got=%b exp=0", c, out_valid);
      end
      step();
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      p1_valid = 1'b1; p1_data = $urandom;
      p2_valid = 1'b1; p2_data = $urandom;
      step();
    end
    n_checks++;
    if ({overflow, out_valid, out_src} !== 4'b1110) begin
      n_errors++; $display("FAIL mid_pre got ovf=%b v=%b s=%b exp 11/1/0", overflow, out_valid, out_src);
    end
    reset = 1'b1;
    step();
    reset    = 1'b0;
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_src, out_data, stall_1, stall_2, flush_1, flush_2, overflow} !== 40'h0) begin
      n_errors++;
      $display("FAIL mid_reset got=%h exp=0",
               {out_valid, out_src, out_data, stall_1, stall_2, flush_1, flush_2, overflow});
    end
    p1_valid = 1'b1; p1_data = 32'h11;
    p2_valid = 1'b1; p2_data = 32'h22;
    out_ready = 1'b1;
    step();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    step();
    n_checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 32'h11}) begin
      n_errors++; $display("FAIL mid_first_grant got=%b/%b/%h exp=1/0/11", out_valid, out_src, out_data);
    end
    step();
    n_checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, 32'h22}) begin
      n_errors++; $display("FAIL mid_second_grant got=%b/%b/%h exp=1/1/22", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 599) == 0);
      p1_valid  = ($urandom_range(0, 3) != 0) && (!stall_1 || $urandom_range(0, 7) == 0);
      p2_valid  = ($urandom_range(0, 3) != 0) && (!stall_2 || $urandom_range(0, 7) == 0);
      p1_data   = $urandom;
      p2_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    reset    = 1'b0;
    p1_valid = 1'b0;
    p2_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    p1_valid  = 1'b0;
    p2_valid  = 1'b0;
    p1_data   = '0;
    p2_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    mon_en = 1'b1;
    test_reset();
    test_single_lane();
    test_both_lanes();
    test_backpressure();
    test_flush_schedule();
    test_flush_drain();
    test_reset_midstream();
    test_random();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
